// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with registered in_ready/out_valid and flush.
// Optional stall counter output enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_count
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             main_valid, skid_valid;
    logic             acc, fire;

    assign main_valid = (state_q != StEmpty);
    assign skid_valid = (state_q == StFull);

    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign in_ready  = reset && !skid_valid;

    assign acc  = in_valid && in_ready;
    assign fire = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Squash drops both entries and any offered bundle; data regs keep stale values.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d     = StOne;
                        main_data_d = in_data;
                    end
                end
                StOne: begin
                    if (acc && fire) begin
                        main_data_d = in_data;
                    end else if (acc) begin
                        state_d     = StFull;
                        skid_data_d = in_data;
                    end else if (fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (fire) begin
                        state_d     = StOne;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_count_q;

    assign stall_count = stall_count_q;

    // Saturating count of cycles where downstream holds off a valid bundle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg; covers the counter when PIPE_STALL_CNT_EN is set.
module tb_pipe_skid_reg;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic [WIDTH-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0]      stall_count;
`endif

    int checks;
    int failures;

    pipe_skid_reg #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .out_data   (out_data)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd11;
        step();
        in_data   = 64'd22;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA5;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset held for two edges with a bundle offered.
        step();
        step();
        check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        check("rel_out_valid", {63'd0, out_valid}, 64'd0);
        check("rel_out_data", out_data, 64'd0);
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Streaming 1..8 at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            step();
            check("stream_valid", {63'd0, out_valid}, 64'd1);
            check("stream_data", out_data, 64'(i));
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", {63'd0, out_valid}, 64'd0);

        // Skid: 11, 22 fill, 33 held off, then drain in order.
        fill_full();
        check("skid_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("skid_head", out_data, 64'd11);
        in_valid = 1'b1;
        in_data  = 64'd33;
        step();
        check("skid_hold_head", out_data, 64'd11);
        check("skid_hold_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        step();
        check("skid_out_22", out_data, 64'd22);
        check("skid_ready_rise", {63'd0, in_ready}, 64'd1);
        step();
        check("skid_out_33", out_data, 64'd33);
        check("skid_out_33_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        step();
        check("skid_empty", {63'd0, out_valid}, 64'd0);

        // Flush in FULL with a bundle offered.
        fill_full();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'd44;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_data_kept", out_data, 64'd11);
        out_ready = 1'b1;
        step();
        check("flush_no_44", {63'd0, out_valid}, 64'd0);

        // Reset mid-FULL.
        fill_full();
        reset = 1'b0;
        step();
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        check("midrst_gone", {63'd0, out_valid}, 64'd0);
        check("midrst_ready", {63'd0, in_ready}, 64'd1);

`ifdef PIPE_STALL_CNT_EN
        // Fresh counter, then five stalled cycles.
        reset = 1'b0;
        step();
        reset     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'd77;
        step();
        in_valid = 1'b0;
        check("cnt_start", 64'(stall_count), 64'd0);
        for (int i = 0; i < 5; i++) step();
        check("cnt_five", 64'(stall_count), 64'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cnt_flush_keep", 64'(stall_count), 64'd5);
        step();
        check("cnt_idle_keep", 64'(stall_count), 64'd5);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("cnt_reset", 64'(stall_count), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
